// File: rtl/vec_add_seq_if.sv
// Handshake and operand/result bus for the sequential vector adder.
// Lane i of every packed vector occupies bits [i*WIDTH +: WIDTH].
interface vec_add_seq_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
);
  logic                     start;
  logic [LANES*WIDTH-1:0]   a_vec;
  logic [LANES*WIDTH-1:0]   b_vec;
  logic                     busy;
  logic                     done;
  logic [LANES*WIDTH-1:0]   sum_vec;
  logic [LANES-1:0]         carry_vec;

  modport master (
    output start, a_vec, b_vec,
    input  busy, done, sum_vec, carry_vec
  );

  modport slave (
    input  start, a_vec, b_vec,
    output busy, done, sum_vec, carry_vec
  );
endinterface

// File: rtl/vec_add_seq.sv
// Multi-cycle vector adder: one lane per clock through a single shared adder.
// Optional build macro VEC_ADD_SATURATE_EN clamps overflowing lanes to all ones.
//
// state | meaning
// IDLE  | waiting for start; holds last results
// RUN   | adding lane idx each cycle, last lane returns to IDLE and pulses done
module vec_add_seq #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  vec_add_seq_if.slave  bus
);
  localparam int              IW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int              VW   = LANES * WIDTH;
  localparam logic [IW-1:0]   LAST = IW'(LANES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic [VW-1:0]      a_q;
  logic [VW-1:0]      b_q;
  logic [VW-1:0]      sum_q;
  logic [LANES-1:0]   carry_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   a_lane;
  logic [WIDTH-1:0]   b_lane;
  logic [WIDTH:0]     raw;
  logic [WIDTH-1:0]   lane_sum;

  always_comb begin
    a_lane = a_q[int'(idx)*WIDTH +: WIDTH];
    b_lane = b_q[int'(idx)*WIDTH +: WIDTH];
    raw    = {1'b0, a_lane} + {1'b0, b_lane};
`ifdef VEC_ADD_SATURATE_EN
    lane_sum = raw[WIDTH] ? {WIDTH{1'b1}} : raw[WIDTH-1:0];
`else
    lane_sum = raw[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a_vec;
            b_q     <= bus.b_vec;
            sum_q   <= '0;
            carry_q <= '0;
            idx     <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[int'(idx)*WIDTH +: WIDTH] <= lane_sum;
          carry_q[idx]                    <= raw[WIDTH];
          if (idx == LAST) begin
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum_vec   = sum_q;
  assign bus.carry_vec = carry_q;
endmodule
